// File: rtl/light_pattern_ctrl.sv
// light_pattern_ctrl: steps one LED through OFF/STEADY/BLINK/BREATHE patterns on debounced button presses.
module light_pattern_ctrl #(
    parameter int CLK_DIV        = 50000,
    parameter int BLINK_TICKS    = 250,
    parameter int PWM_BITS       = 8,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       en,
    output logic [1:0] mode,
    output logic       light,
    output logic       tick
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam int KW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {OFF, STEADY, BLINK, BREATHE} mode_e;

    mode_e               mode_q, mode_d;
    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [KW-1:0]       deb_cnt_q, deb_cnt_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
    logic                tick_q, tick_d, sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
    logic                phase_q, phase_d, dir_q, dir_d, light_q, light_d;
    logic                tick_en, deb_hit, adv, blink_wrap, step, turn;

    always_comb begin
        // a tick whose enable dropped in the same cycle is swallowed
        tick_en    = tick_q && en;
        div_cnt_d  = !en ? div_cnt_q : (div_cnt_q == DW'(CLK_DIV - 1)) ? '0 : div_cnt_q + DW'(1);
        tick_d     = en && (div_cnt_q == DW'(CLK_DIV - 1));
        sync1_d    = btn;
        sync2_d    = sync1_q;
        deb_hit    = tick_en && (sync2_q != deb_q) && (deb_cnt_q == KW'(DEBOUNCE_TICKS - 1));
        deb_cnt_d  = !tick_en ? deb_cnt_q : (sync2_q == deb_q || deb_hit) ? '0 : deb_cnt_q + KW'(1);
        deb_d      = deb_hit ? ~deb_q : deb_q;
        adv        = deb_hit && !deb_q;
        mode_d     = adv ? mode_e'(mode_q + 2'd1) : mode_q;
        blink_wrap = blink_cnt_q == BW'(BLINK_TICKS - 1);
        blink_cnt_d = adv ? '0 : (tick_en && mode_q == BLINK) ? (blink_wrap ? '0 : blink_cnt_q + BW'(1)) : blink_cnt_q;
        phase_d    = adv ? 1'b1 : (tick_en && mode_q == BLINK && blink_wrap) ? ~phase_q : phase_q;
        // dir_q: 0 = up, 1 = down; at either end the direction flips and the step follows it
        step       = tick_en && mode_q == BREATHE;
        turn       = dir_q ? (duty_q == '0) : (duty_q == '1);
        dir_d      = adv ? 1'b0 : (step && turn) ? ~dir_q : dir_q;
        duty_d     = adv ? '0 : !step ? duty_q : (dir_q ^ turn) ? duty_q - PWM_BITS'(1) : duty_q + PWM_BITS'(1);
        pwm_cnt_d  = adv ? '0 : en ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        light_d    = !en ? 1'b0 :
                     (mode_q == OFF)    ? 1'b0 :
                     (mode_q == STEADY) ? 1'b1 :
                     (mode_q == BLINK)  ? phase_q : (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= OFF;
            div_cnt_q   <= '0;
            tick_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            pwm_cnt_q   <= '0;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            light_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            div_cnt_q   <= div_cnt_d;
            tick_q      <= tick_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            light_q     <= light_d;
        end
    end

    assign mode  = mode_q;
    assign light = light_q;
    assign tick  = tick_en;
endmodule

// File: tb/tb_light_pattern_ctrl.sv
// tb_light_pattern_ctrl: directed checks of light_pattern_ctrl with a fast time base.
module tb_light_pattern_ctrl;
    logic       clk = 1'b0, rst = 1'b0, btn = 1'b0, en = 1'b1;
    logic [1:0] mode;
    logic       light, tick;
    int         checks = 0, passed = 0;

    light_pattern_ctrl #(.CLK_DIV(4), .BLINK_TICKS(3), .PWM_BITS(3), .DEBOUNCE_TICKS(2)) dut (
        .clk(clk), .rst(rst), .btn(btn), .en(en), .mode(mode), .light(light), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick;
        int k = 0;
        do begin
            step(1);
            k++;
        end while (tick !== 1'b1 && k < 20);
        checks++;
        if (tick !== 1'b1) $display("FAIL tick_timeout got %b want 1", tick);
        else passed++;
    endtask

    task automatic settle(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic press(input logic [1:0] exp_mode);
        logic [1:0] old;
        int n = 0, k = 0;
        old = mode;
        wait_tick();
        step(1);
        btn = 1'b1;
        do begin
            step(1);
            k++;
            if (mode === old && tick === 1'b1) n++;
        end while (mode === old && k < 40);
        btn = 1'b0;
        checks++;
        if (mode !== exp_mode) $display("FAIL press_mode got %0d want %0d", mode, exp_mode);
        else passed++;
        checks++;
        if (n !== 2) $display("FAIL press_latency got %0d ticks want 2", n);
        else passed++;
        if (exp_mode == 2'd1) begin
            checks++;
            if (light !== 1'b0) $display("FAIL steady_light_pre got %b want 0", light);
            else passed++;
            step(1);
            checks++;
            if (light !== 1'b1) $display("FAIL steady_light got %b want 1", light);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b1; btn = 1'b0;
        repeat (3) begin
            step(1);
            checks++;
            if (mode !== 2'd0 || light !== 1'b0 || tick !== 1'b0)
                $display("FAIL reset_hold got mode=%0d light=%b tick=%b want 0/0/0", mode, light, tick);
            else passed++;
        end
        rst = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step(1);
            checks++;
            if (tick !== (c % 4 == 0)) $display("FAIL reset_tick c=%0d got %b want %b", c, tick, c % 4 == 0);
            else passed++;
            checks++;
            if (mode !== 2'd0 || light !== 1'b0) $display("FAIL reset_out got mode=%0d light=%b want 0/0", mode, light);
            else passed++;
        end
    endtask

    task automatic test_glitch;
        wait_tick();
        step(1);
        btn = 1'b1;
        step(4);
        btn = 1'b0;
        step(16);
        checks++;
        if (mode !== 2'd0) $display("FAIL glitch_mode got %0d want 0", mode);
        else passed++;
    endtask

    task automatic test_mode_walk;
        press(2'd1); settle(5);
        press(2'd2); settle(5);
        press(2'd3); settle(5);
        press(2'd0); settle(5);
    endtask

    task automatic test_blink;
        press(2'd1); settle(5);
        press(2'd2);
        step(1);
        checks++;
        if (light !== 1'b1) $display("FAIL blink_k0 got %b want 1", light);
        else passed++;
        for (int k = 1; k < 12; k++) begin
            wait_tick();
            step(2);
            checks++;
            if (light !== ((k / 3) % 2 == 0)) $display("FAIL blink_k%0d got %b want %b", k, light, (k / 3) % 2 == 0);
            else passed++;
        end
    endtask

    task automatic test_breathe;
        int seq[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        int pwm = 0, duty = 0, ticks = 0, k = 0, p_pwm, p_duty;
        logic tk;
        press(2'd3);
        while (ticks < 16 && k < 200) begin
            p_pwm  = pwm;
            p_duty = duty;
            tk     = tick;
            step(1);
            k++;
            checks++;
            if (light !== (p_pwm < p_duty)) $display("FAIL breathe_light pwm=%0d duty=%0d got %b want %b", p_pwm, p_duty, light, p_pwm < p_duty);
            else passed++;
            pwm = (pwm + 1) % 8;
            if (tk) begin
                ticks++;
                duty = seq[ticks];
                checks++;
                if (int'(dut.duty_q) !== duty) $display("FAIL breathe_duty t=%0d got %0d want %0d", ticks, dut.duty_q, duty);
                else passed++;
            end
        end
    endtask

    task automatic test_enable;
        press(2'd0); settle(5);
        press(2'd1); settle(5);
        press(2'd2);
        repeat (4) begin
            wait_tick();
            step(1);
        end
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) btn = 1'b1;
            if (i == 12) btn = 1'b0;
            step(1);
            checks++;
            if (light !== 1'b0 || tick !== 1'b0 || mode !== 2'd2)
                $display("FAIL enable_gap i=%0d got light=%b tick=%b mode=%0d want 0/0/2", i, light, tick, mode);
            else passed++;
        end
        en = 1'b1;
        checks++;
        if (dut.blink_cnt_q !== 2'd1 || dut.phase_q !== 1'b0)
            $display("FAIL enable_hold got cnt=%0d phase=%b want 1/0", dut.blink_cnt_q, dut.phase_q);
        else passed++;
        step(1);
        checks++;
        if (light !== 1'b0) $display("FAIL enable_resume0 got %b want 0", light);
        else passed++;
        wait_tick();
        step(2);
        checks++;
        if (light !== 1'b0) $display("FAIL enable_resume1 got %b want 0", light);
        else passed++;
        wait_tick();
        step(2);
        checks++;
        if (light !== 1'b1 || mode !== 2'd2) $display("FAIL enable_resume2 got light=%b mode=%0d want 1/2", light, mode);
        else passed++;
    endtask

    task automatic test_reset_mid;
        press(2'd3);
        repeat (5) begin
            wait_tick();
            step(1);
        end
        checks++;
        if (dut.duty_q !== 3'd5) $display("FAIL mid_duty got %0d want 5", dut.duty_q);
        else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mode !== 2'd0 || light !== 1'b0 || dut.duty_q !== 3'd0)
            $display("FAIL mid_reset got mode=%0d light=%b duty=%0d want 0/0/0", mode, light, dut.duty_q);
        else passed++;
        step(2);
        rst = 1'b1;
        step(2);
        checks++;
        if (mode !== 2'd0 || light !== 1'b0) $display("FAIL mid_after got mode=%0d light=%b want 0/0", mode, light);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_mode_walk();
        test_blink();
        test_breathe();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/light_pattern_ctrl.md
Name: light_pattern_ctrl

Overview:
- Controller that sequences the single `light` output of the present board.
- A debounced mode button steps the block through OFF, STEADY, BLINK and BREATHE patterns.
- Contains the time-base prescaler, the blink and breathe (PWM) generators, and the mode state machine.
- The `present` top instantiates it and drives the board LED from `light`.

Parameters:
- CLK_DIV, 50000: clk cycles per time-base tick (≥2).
- BLINK_TICKS, 250: ticks per blink half-period (≥1).
- PWM_BITS, 8: PWM counter and duty width; duty range 0..2^PWM_BITS-1.
- DEBOUNCE_TICKS, 20: consecutive ticks a new button level must persist before it is accepted (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- btn  in  1  raw mode button; asynchronous to clk; active-high.
- en  in  1  global enable.
- mode  out  2  current mode: 0 OFF, 1 STEADY, 2 BLINK, 3 BREATHE.
- light  out  1  LED drive; registered.
- tick  out  1  one-clk pulse per time-base tick.

Behaviour:
- Reset (rst=0, async; release synchronous to clk):
  - Outputs: mode=0, light=0, tick=0.
  - Internals: div_cnt=0, sync flops=0, debounced level=0, deb_cnt=0, blink_cnt=0, phase=1, pwm_cnt=0, duty=0, dir=up.
- Reset mid-pattern returns to OFF immediately.
- Prescaler:
  - While en=1, div_cnt counts 0..CLK_DIV-1 and wraps.
  - tick=1 during the cycle after div_cnt==CLK_DIV-1, so tick period = CLK_DIV cycles.
  - While en=0, div_cnt holds and tick=0.
- Button path:
  - Two-flop synchronizer feeds the debouncer, which samples only on tick.
  - If the sample ≠ the debounced level, deb_cnt increments. Otherwise deb_cnt clears.
  - When deb_cnt reaches DEBOUNCE_TICKS, the debounced level flips and deb_cnt clears.
  - A 0→1 flip of the debounced level is the mode-advance event.
  - While en=0 there are no ticks, so the button is ignored.
- Mode FSM:
  - On a mode-advance event, mode advances OFF→STEADY→BLINK→BREATHE→OFF the next clk.
  - Every mode change reloads the pattern state: blink_cnt=0, phase=1, duty=0, dir=up, pwm_cnt=0.
- light (registered; reflects the mode/pattern state one clk later):
  - en=0: light=0 regardless of mode; pattern state holds.
  - OFF: 0.
  - STEADY: 1.
  - BLINK:
    - light=phase.
    - On each tick, blink_cnt increments.
    - At BLINK_TICKS-1 it wraps to 0 and phase toggles, giving BLINK_TICKS ticks high then BLINK_TICKS ticks low.
  - BREATHE:
    - pwm_cnt free-runs 0..2^PWM_BITS-1 every clk while en=1.
    - light = (pwm_cnt < duty).
    - On each tick, duty steps by 1 in direction dir.
    - At duty=max with dir=up, dir flips to down and duty decrements on the next tick.
    - At duty=0 with dir=down, dir flips to up.
    - duty never wraps. duty=0 gives constant 0; duty=max gives 1 on all but one clk per PWM period.
- Simultaneous events:
  - A mode-advance event on the same clk as a tick: the mode change wins and the pattern update from that tick is discarded.
  - en falling on the same clk as a tick: the tick is not generated.

Test Plan (CLK_DIV=4, BLINK_TICKS=3, PWM_BITS=3, DEBOUNCE_TICKS=2):
- Reset:
  - Stimulus: rst=0 for 3 clk, then release with en=1, btn=0.
  - Required: mode=0, light=0 throughout; tick pulses every 4 clk, the first 4 clk after release.
- Debounce and mode walk:
  - Stimulus: btn high for 1 tick, then low. Then btn high and held ≥3 ticks, released ≥3 ticks, repeated 4×.
  - Required: the single-tick glitch leaves mode=0. The presses give mode=1,2,3,0, each changing 2 ticks after the press. light=1 from the clk after mode=1.
- Blink:
  - Stimulus: in mode 2, observe 12 ticks.
  - Required: light = 1,1,1,0,0,0,1,1,1,0,0,0 per tick interval.
- Breathe:
  - Stimulus: in mode 3, observe 16 ticks.
  - Required: duty sequence 0,1,…,7,6,…,0. High clks per 8-clk PWM period equal duty (0 at duty=0, 7 at duty=7).
- Enable gating:
  - Stimulus: in mode 2 mid-phase, en=0 for 20 clk, then en=1.
  - Required: light=0 and tick=0 during the gap; button presses during the gap are ignored; the blink resumes with the same blink_cnt and phase.
- Reset mid-operation:
  - Stimulus: in mode 3 with duty=5, assert rst=0 asynchronously between edges.
  - Required: mode=0 and light=0 immediately, without waiting for a clk edge.
